// File: rtl/flux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// flux_rr_scheduler
//
// Round-robin scheduler for multi-flux HEVC actors. Each cycle it grants at
// most one flux whose input FIFO has data and whose output FIFO has room. A
// granted flux may keep the grant for up to BURST consecutive cycles. After
// that, the search start rotates past it so that no flux can starve the others.
//
// Ports:
//   clk          - clock; all state updates on its rising edge
//   rst          - synchronous, active-high reset
//   en           - scheduler enable; when low, no grant is made and state holds
//   empty[FLUX]  - per-flux input FIFO empty flags
//   full[FLUX]   - per-flux output FIFO full flags
//   read[FLUX]   - one-hot read strobe to the granted input FIFO (or zero)
//   write        - write strobe to the shared output FIFO
//   tag          - index of the granted flux (0 when write is low)
//   burst_active - high while a burst is in progress
// ---------------------------------------------------------------------------
module flux_rr_scheduler #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int BURST     = 4,
    parameter int CNT_WIDTH = $clog2(BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [FLUX-1:0]      empty,
    input  logic [FLUX-1:0]      full,
    output logic [FLUX-1:0]      read,
    output logic                 write,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 burst_active
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]           state, state_n;
    logic [TAG_WIDTH-1:0] ptr, ptr_n;
    logic [TAG_WIDTH-1:0] owner, owner_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;

    logic [FLUX-1:0]      elig;
    logic [TAG_WIDTH-1:0] base;
    logic                 found;
    logic [TAG_WIDTH-1:0] g_search;
    logic                 grant;
    logic [TAG_WIDTH-1:0] gnt;

    // Explicit wrap so that FLUX does not have to be a power of two.
    function automatic logic [TAG_WIDTH-1:0] next_idx(input logic [TAG_WIDTH-1:0] i);
        return (i == TAG_WIDTH'(FLUX - 1)) ? '0 : i + TAG_WIDTH'(1);
    endfunction

    // First eligible index scanning base, base+1, ... (mod FLUX).
    // Returns {found, index}. This is a linear priority chain of depth FLUX.
    function automatic logic [TAG_WIDTH:0] search(input logic [FLUX-1:0]      e,
                                                  input logic [TAG_WIDTH-1:0] b);
        logic [TAG_WIDTH-1:0] idx;
        logic                 f;
        logic [TAG_WIDTH-1:0] g;
        idx = b;
        f   = 1'b0;
        g   = '0;
        for (int k = 0; k < FLUX; k++) begin
            if (!f && e[idx]) begin
                f = 1'b1;
                g = idx;
            end
            idx = next_idx(idx);
        end
        return {f, g};
    endfunction

    always_comb begin
        elig = ~empty & ~full;

        // The search runs from ptr while idle. While a burst is running, it
        // runs from past the owner, so the result is only used when the owner
        // has just become ineligible (the burst breaks with no bubble).
        base = (state == ST_BURST) ? next_idx(owner) : ptr;
        {found, g_search} = search(elig, base);

        grant   = 1'b0;
        gnt     = '0;
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;

        if (en) begin
            if (state == ST_BURST && elig[owner]) begin
                grant = 1'b1;
                gnt   = owner;
                if (cnt + CNT_WIDTH'(1) == CNT_WIDTH'(BURST)) begin
                    ptr_n   = next_idx(owner);
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end else if (found) begin
                grant = 1'b1;
                gnt   = g_search;
                if (BURST == 1) begin
                    ptr_n   = next_idx(g_search);
                    state_n = ST_IDLE;
                end else begin
                    owner_n = g_search;
                    cnt_n   = CNT_WIDTH'(1);
                    state_n = ST_BURST;
                end
            end else if (state == ST_BURST) begin
                // The owner dropped out and nobody else is ready: give up the burst.
                ptr_n   = next_idx(owner);
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        end

        read = '0;
        if (grant) begin
            read[gnt] = 1'b1;
        end
        write        = grant;
        tag          = gnt;
        burst_active = (state == ST_BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
module tb_flux_rr_scheduler;

    typedef struct packed {
        logic [3:0] rd;
        logic       wr;
        logic [1:0] tg;
        logic       ba;
    } obs_t;

    localparam int DA = 0;  // FLUX=4, BURST=2
    localparam int DB = 1;  // FLUX=4, BURST=4
    localparam int DC = 2;  // FLUX=3, BURST=2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic [3:0] empty_a = '1, full_a = '0, read_a;
    logic       write_a, ba_a;
    logic [1:0] tag_a;

    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [3:0] empty_b = '1, full_b = '0, read_b;
    logic       write_b, ba_b;
    logic [1:0] tag_b;

    logic       rst_c = 1'b1, en_c = 1'b0;
    logic [2:0] empty_c = '1, full_c = '0, read_c;
    logic       write_c, ba_c;
    logic [1:0] tag_c;

    flux_rr_scheduler #(.FLUX(4), .BURST(2)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .empty(empty_a), .full(full_a),
        .read(read_a), .write(write_a), .tag(tag_a), .burst_active(ba_a));

    flux_rr_scheduler #(.FLUX(4), .BURST(4)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .empty(empty_b), .full(full_b),
        .read(read_b), .write(write_b), .tag(tag_b), .burst_active(ba_b));

    flux_rr_scheduler #(.FLUX(3), .BURST(2)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .empty(empty_c), .full(full_c),
        .read(read_c), .write(write_c), .tag(tag_c), .burst_active(ba_c));

    obs_t sb[$];
    obs_t got, exp_v;
    int   n_pass = 0;
    int   n_total = 0;

    // Expected observation: a grant drives exactly the read bit of its tag.
    function automatic obs_t mk(input logic wr, input int tg, input logic ba);
        obs_t o;
        o.wr = wr;
        o.tg = wr ? 2'(tg) : 2'd0;
        o.rd = wr ? (4'b0001 << tg) : 4'b0000;
        o.ba = ba;
        return o;
    endfunction

    function automatic obs_t observe(input int which);
        obs_t o;
        case (which)
            DA:      o = '{rd: read_a, wr: write_a, tg: tag_a, ba: ba_a};
            DB:      o = '{rd: read_b, wr: write_b, tg: tag_b, ba: ba_b};
            default: o = '{rd: {1'b0, read_c}, wr: write_c, tg: tag_c, ba: ba_c};
        endcase
        return o;
    endfunction

    // Apply inputs shortly after the rising edge.
    task automatic drive(input int which, input logic r, input logic e,
                         input logic [3:0] em, input logic [3:0] fu);
        @(posedge clk);
        #1;
        case (which)
            DA: begin rst_a = r; en_a = e; empty_a = em; full_a = fu; end
            DB: begin rst_b = r; en_b = e; empty_b = em; full_b = fu; end
            default: begin rst_c = r; en_c = e; empty_c = em[2:0]; full_c = fu[2:0]; end
        endcase
    endtask

    task automatic do_reset(input int which);
        drive(which, 1'b1, 1'b0, 4'hF, 4'h0);
    endtask

    task automatic test_reset;
        do_reset(DA);
        drive(DA, 1'b0, 1'b0, 4'h0, 4'h0);
        sb.push_back(mk(1'b0, 0, 1'b0));
        @(negedge clk);
        exp_v = sb.pop_front(); got = observe(DA); n_total++;
        if (got !== exp_v)
            $display("FAIL reset_en0: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                     got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
        else n_pass++;
        drive(DA, 1'b0, 1'b1, 4'h0, 4'h0);
        sb.push_back(mk(1'b1, 0, 1'b0));
        @(negedge clk);
        exp_v = sb.pop_front(); got = observe(DA); n_total++;
        if (got !== exp_v)
            $display("FAIL reset_first_grant: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                     got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
        else n_pass++;
    endtask

    task automatic test_rotation;
        int tags[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        do_reset(DA);
        for (int i = 0; i < 9; i++) begin
            drive(DA, 1'b0, 1'b1, 4'h0, 4'h0);
            sb.push_back(mk(1'b1, tags[i], (i % 2) == 1));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DA); n_total++;
            if (got !== exp_v)
                $display("FAIL rotation[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    task automatic test_burst_break;
        logic [3:0] em[4]  = '{4'b1101, 4'b0010, 4'b0010, 4'b0010};
        int         tg[4]  = '{1, 2, 2, 3};
        logic       ba[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset(DA);
        for (int i = 0; i < 4; i++) begin
            drive(DA, 1'b0, 1'b1, em[i], 4'h0);
            sb.push_back(mk(1'b1, tg[i], ba[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DA); n_total++;
            if (got !== exp_v)
                $display("FAIL burst_break[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        do_reset(DA);
        for (int i = 0; i < 12; i++) begin
            drive(DA, 1'b0, 1'b1, 4'h0, 4'b0001);
            sb.push_back(mk(1'b1, 1 + (i / 2) % 3, (i % 2) == 1));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DA); n_total++;
            if (got !== exp_v)
                $display("FAIL backpressure[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    task automatic test_none_eligible;
        logic [3:0] em[5] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
        logic       wr[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int         tg[5] = '{0, 0, 0, 0, 1};
        logic       ba[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset(DA);
        for (int i = 0; i < 5; i++) begin
            drive(DA, 1'b0, 1'b1, em[i], 4'h0);
            sb.push_back(mk(wr[i], tg[i], ba[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DA); n_total++;
            if (got !== exp_v)
                $display("FAIL none_eligible[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    task automatic test_enable_hold;
        logic       en[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] em[6] = '{4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       wr[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         tg[6] = '{2, 0, 0, 0, 2, 0};
        logic       ba[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset(DC);
        for (int i = 0; i < 6; i++) begin
            drive(DC, 1'b0, en[i], em[i], 4'h0);
            sb.push_back(mk(wr[i], tg[i], ba[i]));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DC); n_total++;
            if (got !== exp_v)
                $display("FAIL enable_hold[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst;
        do_reset(DB);
        // Two grants to flux 3, then reset while it still owns the burst.
        for (int i = 0; i < 3; i++) begin
            drive(DB, (i == 2), 1'b1, (i == 2) ? 4'h0 : 4'b0111, 4'h0);
            sb.push_back(mk(1'b1, 3, i != 0));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DB); n_total++;
            if (got !== exp_v)
                $display("FAIL mid_burst_pre[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
        for (int i = 0; i < 13; i++) begin
            drive(DB, 1'b0, 1'b1, 4'h0, 4'h0);
            sb.push_back(mk(1'b1, i / 4, (i % 4) != 0));
            @(negedge clk);
            exp_v = sb.pop_front(); got = observe(DB); n_total++;
            if (got !== exp_v)
                $display("FAIL mid_burst_post[%0d]: got rd=%b wr=%b tag=%0d ba=%b, expected rd=%b wr=%b tag=%0d ba=%b",
                         i, got.rd, got.wr, got.tg, got.ba, exp_v.rd, exp_v.wr, exp_v.tg, exp_v.ba);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_burst_break();
        test_backpressure();
        test_none_eligible();
        test_enable_hold();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
